// File: rtl/nanov_spi_pkg.sv
// Shared SPI definitions for the nanoV serial RAM responder and the master-side flash model.
package nanov_spi_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_READ   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_IGNORE = 3'd5
   } spi_state_e;

endpackage

// File: rtl/nanov_spi_ram_mem.sv
// Byte RAM with an SPI write port, a backdoor load port and a combinational read port.
module nanov_spi_ram_mem #(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(MEM_BYTES)-1:0] waddr,
   input  logic [7:0]                   wdata,
   input  logic                         load_en,
   input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
   input  logic [7:0]                   load_data,
   input  logic [$clog2(MEM_BYTES)-1:0] raddr,
   output logic [7:0]                   rdata
);

   logic [7:0] mem [MEM_BYTES];

   // SPI write is issued last so it wins a same-byte collision with the backdoor
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      if (we)      mem[waddr]     <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/nanov_spi_ram_responder.sv
// SPI serial-RAM responder for the nanoV core: command/address in MSB first, data LSB first.
module nanov_spi_ram_responder
   import nanov_spi_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096,
   parameter int unsigned ADDR_BITS = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         spi_select,
   input  logic                         spi_clk_enable,
   input  logic                         spi_mosi,
   output logic                         spi_miso,
   input  logic                         load_en,
   input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
   input  logic [7:0]                   load_data,
   output logic                         busy,
   output logic                         cmd_error
);

   localparam int unsigned AW    = $clog2(MEM_BYTES);
   localparam int unsigned CNT_W = $clog2(ADDR_BITS + 1);

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [7:0]        rd_shift_q, rd_shift_d;
   logic [7:0]        wr_shift_q, wr_shift_d;
   logic              miso_q, miso_d;
   logic              busy_q, busy_d;
   logic              cmd_error_q, cmd_error_d;

   logic              mem_we_c;
   logic [7:0]        mem_wdata_c;
   logic [AW-1:0]     mem_raddr_c;
   logic [7:0]        mem_rdata;
   logic [7:0]        cmd_next_c;
   logic [AW-1:0]     addr_shift_c;
   logic [AW-1:0]     addr_inc_c;

   assign cmd_next_c   = {cmd_q[6:0], spi_mosi};
   assign addr_shift_c = {addr_q[AW-2:0], spi_mosi};
   assign addr_inc_c   = AW'(addr_q + 1'b1);
   assign mem_wdata_c  = {spi_mosi, wr_shift_q[7:1]};

   nanov_spi_ram_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
      .clk       (clk),
      .we        (mem_we_c),
      .waddr     (addr_q),
      .wdata     (mem_wdata_c),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .raddr     (mem_raddr_c),
      .rdata     (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         cmd_q       <= '0;
         addr_q      <= '0;
         rd_shift_q  <= '0;
         wr_shift_q  <= '0;
         miso_q      <= 1'b0;
         busy_q      <= 1'b0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         rd_shift_q  <= rd_shift_d;
         wr_shift_q  <= wr_shift_d;
         miso_q      <= miso_d;
         busy_q      <= busy_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      rd_shift_d  = rd_shift_q;
      wr_shift_d  = wr_shift_q;
      miso_d      = miso_q;
      cmd_error_d = 1'b0;
      mem_we_c    = 1'b0;
      mem_raddr_c = addr_q;

      if (spi_select) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         bit_d      = '0;
         wr_shift_d = '0;
         miso_d     = 1'b0;
      end else if (spi_clk_enable) begin
         case (state_q)
            ST_IDLE: begin
               cmd_d   = {7'd0, spi_mosi};
               cnt_d   = CNT_W'(1);
               miso_d  = 1'b0;
               state_d = ST_CMD;
            end
            ST_CMD: begin
               cmd_d  = cmd_next_c;
               cnt_d  = CNT_W'(cnt_q + 1'b1);
               miso_d = 1'b0;
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d = '0;
                  if (cmd_next_c == SPI_CMD_READ || cmd_next_c == SPI_CMD_WRITE) begin
                     state_d = ST_ADDR;
                  end else begin
                     state_d     = ST_IGNORE;
                     cmd_error_d = 1'b1;
                  end
               end
            end
            ST_ADDR: begin
               // Upper address bits shift out of the top, leaving the address modulo MEM_BYTES
               addr_d = addr_shift_c;
               cnt_d  = CNT_W'(cnt_q + 1'b1);
               miso_d = 1'b0;
               if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                  cnt_d = '0;
                  if (cmd_q == SPI_CMD_READ) begin
                     mem_raddr_c = addr_shift_c;
                     rd_shift_d  = mem_rdata;
                     miso_d      = mem_rdata[0];
                     bit_d       = 3'd1;
                     state_d     = ST_READ;
                  end else begin
                     bit_d   = '0;
                     state_d = ST_WRITE;
                  end
               end
            end
            ST_READ: begin
               // Pointer wrapping to 0 means the next byte is fetched and latched now
               bit_d = 3'(bit_q + 3'd1);
               if (bit_q == 3'd0) begin
                  addr_d      = addr_inc_c;
                  mem_raddr_c = addr_inc_c;
                  rd_shift_d  = mem_rdata;
                  miso_d      = mem_rdata[0];
               end else begin
                  miso_d = rd_shift_q[bit_q];
               end
            end
            ST_WRITE: begin
               wr_shift_d = mem_wdata_c;
               bit_d      = 3'(bit_q + 3'd1);
               miso_d     = 1'b0;
               if (bit_q == 3'd7) begin
                  mem_we_c = 1'b1;
                  addr_d   = addr_inc_c;
               end
            end
            ST_IGNORE: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign spi_miso  = miso_q;
   assign busy      = busy_q;
   assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_nanov_spi_ram_responder.sv
// Directed bench for the nanoV SPI RAM responder; inputs change and outputs are sampled on negedge.
module tb_nanov_spi_ram_responder;

   localparam int unsigned MEM_BYTES = 4096;
   localparam int unsigned AW        = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          spi_select;
   logic          spi_clk_enable;
   logic          spi_mosi;
   logic          spi_miso;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [7:0]    load_data;
   logic          busy;
   logic          cmd_error;

   int n_checks = 0;
   int n_errors = 0;

   nanov_spi_ram_responder #(.MEM_BYTES(MEM_BYTES), .ADDR_BITS(24)) dut (
      .clk            (clk),
      .rst            (rst),
      .spi_select     (spi_select),
      .spi_clk_enable (spi_clk_enable),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .busy           (busy),
      .cmd_error      (cmd_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      spi_select     = 1'b0;
      spi_clk_enable = 1'b1;
      spi_mosi       = b;
      tick();
   endtask

   task automatic send_cmd(input logic [7:0] c);
      for (int i = 7; i >= 0; i--) send_bit(c[i]);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) send_bit(a[i]);
   endtask

   task automatic send_data(input logic [7:0] d);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
   endtask

   // Samples the bit currently on miso, then clocks one bit cycle
   task automatic read_byte(output logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         v[i] = spi_miso;
         send_bit(1'b0);
      end
   endtask

   task automatic deselect();
      spi_select     = 1'b1;
      spi_clk_enable = 1'b0;
      spi_mosi       = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] v;

      rst            = 1'b1;
      spi_select     = 1'b1;
      spi_clk_enable = 1'b0;
      spi_mosi       = 1'b0;
      load_en        = 1'b0;
      load_addr      = '0;
      load_data      = '0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      check("reset_miso", 32'(spi_miso), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_err", 32'(cmd_error), 32'd0);

      preload(12'h010, 8'h93);
      preload(12'h011, 8'h00);
      preload(12'hFFF, 8'h5A);
      preload(12'h000, 8'hC3);
      preload(12'h030, 8'h77);
      preload(12'h004, 8'hE1);
      preload(12'h040, 8'h11);
      check("idle_busy", 32'(busy), 32'd0);

      // Sequential read: bit 0 of 0x93 is on miso right after the last address bit
      send_cmd(8'h03);
      check("cmd_busy", 32'(busy), 32'd1);
      send_addr(24'h000010);
      check("rd_first_bit", 32'(spi_miso), 32'd1);
      read_byte(v);
      check("rd_byte0", 32'(v), 32'h93);
      read_byte(v);
      check("rd_byte1", 32'(v), 32'h00);
      deselect();
      check("rd_end_busy", 32'(busy), 32'd0);
      check("rd_end_miso", 32'(spi_miso), 32'd0);

      // Write two bytes then read them back
      send_cmd(8'h02);
      send_addr(24'h000020);
      send_data(8'hA5);
      check("wr_miso", 32'(spi_miso), 32'd0);
      send_data(8'h3C);
      deselect();
      send_cmd(8'h03);
      send_addr(24'h000020);
      read_byte(v);
      check("wb_byte0", 32'(v), 32'hA5);
      read_byte(v);
      check("wb_byte1", 32'(v), 32'h3C);
      deselect();

      // Read across the top of memory with an enable gap mid-byte
      send_cmd(8'h03);
      send_addr(24'h000FFF);
      for (int i = 0; i < 8; i++) begin
         v[i] = spi_miso;
         if (i == 3) begin
            spi_clk_enable = 1'b0;
            for (int g = 0; g < 3; g++) begin
               tick();
               check("gap_hold", 32'(spi_miso), 32'd1);
            end
         end
         send_bit(1'b0);
      end
      check("wrap_fff", 32'(v), 32'h5A);
      read_byte(v);
      check("wrap_000", 32'(v), 32'hC3);
      deselect();

      // Aborted partial write leaves the byte untouched
      send_cmd(8'h02);
      send_addr(24'h000030);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      deselect();
      check("abort_busy", 32'(busy), 32'd0);
      send_cmd(8'h03);
      send_addr(24'h000030);
      read_byte(v);
      check("abort_byte", 32'(v), 32'h77);
      deselect();

      // Unsupported command 0x0B
      for (int i = 7; i >= 1; i--) begin
         send_bit(1'(8'h0B >> i));
         check("bad_pre_err", 32'(cmd_error), 32'd0);
      end
      send_bit(1'b1);
      check("bad_err_pulse", 32'(cmd_error), 32'd1);
      check("bad_busy", 32'(busy), 32'd1);
      send_bit(1'b1);
      check("bad_err_clear", 32'(cmd_error), 32'd0);
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b1);
         check("bad_miso", 32'(spi_miso), 32'd0);
      end
      deselect();
      check("bad_busy_end", 32'(busy), 32'd0);

      // Upper address bits are discarded
      send_cmd(8'h03);
      send_addr(24'h801004);
      read_byte(v);
      check("hi_addr", 32'(v), 32'hE1);
      deselect();

      // SPI write beats a simultaneous backdoor write to the same byte
      send_cmd(8'h02);
      send_addr(24'h000040);
      for (int i = 0; i < 7; i++) send_bit(1'(8'h6D >> i));
      load_en   = 1'b1;
      load_addr = 12'h040;
      load_data = 8'hFF;
      send_bit(1'b0);
      load_en   = 1'b0;
      deselect();
      send_cmd(8'h03);
      send_addr(24'h000040);
      read_byte(v);
      check("wr_priority", 32'(v), 32'h6D);
      deselect();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/nanov_spi_ram_responder.md
Name: nanov_spi_ram_responder

Overview:
- SPI responder (serial RAM) at the far end of the nanoV core's instruction/data SPI bus.
- Receives command and address from the CPU's SPI master and streams instruction or load data back.
- Accepts store data from the CPU.
- Used in the FPGA/sim top level in place of an external SPI RAM. Runs on the CPU clock; a bit moves only on cycles where the master's clock enable is high.

Parameters:
- MEM_BYTES, 4096, RAM size in bytes (power of 2). Address wraps modulo MEM_BYTES.
- ADDR_BITS, 24, width of the address phase on the wire.

Ports:
- clk  in  1  system clock (same as CPU)
- rst  in  1  synchronous, active-high reset
- spi_select  in  1  chip select, active low
- spi_clk_enable  in  1  bit-transfer qualifier; bit cycle = spi_clk_enable high and spi_select low
- spi_mosi  in  1  master-out data (CPU spi_out)
- spi_miso  out  1  responder-out data (CPU spi_data_in), registered
- load_en  in  1  backdoor byte write, usable any time
- load_addr  in  $clog2(MEM_BYTES)  backdoor byte address
- load_data  in  8  backdoor byte
- busy  out  1  high when not in IDLE
- cmd_error  out  1  one-cycle pulse when an unsupported command byte completes

Behaviour:
- Reset: state IDLE, spi_miso=0, busy=0, cmd_error=0, all counters 0. Memory contents are not reset.
- spi_select high for any cycle forces IDLE next cycle from every state (abort). An in-progress partial write byte is discarded. spi_miso goes to 0.
- Non-bit cycles (enable low, select low) hold all state, including spi_miso.
- FSM states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- IDLE:
  - On the first bit cycle, shift the bit into the command register and go to CMD with bit count 1.
- CMD:
  - 8 bits total, MSB first.
  - On the 8th bit: 0x03 goes to ADDR (read); 0x02 goes to ADDR (write); any other value goes to IGNORE and pulses cmd_error.
- ADDR:
  - ADDR_BITS bits, MSB first.
  - Stored address = received value modulo MEM_BYTES; upper bits are ignored.
  - On the last address bit of a read, on that same clock edge: spi_miso = bit 0 of mem[addr], bit pointer = 1, go to READ. The master samples data bit 0 on its next bit cycle. No dummy cycles.
- READ:
  - Each bit cycle drives the next bit, LSB first within each byte.
  - After bit 7 of a byte: addr = addr+1 (wrap MEM_BYTES-1 to 0), then bit 0 of the new byte.
  - Continuous until select rises.
- WRITE:
  - Each bit cycle shifts spi_mosi into a byte register, LSB first.
  - On the 8th bit: mem[addr] <= assembled byte, addr increments with wrap.
  - spi_miso = 0 throughout.
- IGNORE:
  - spi_miso = 0. Stay until select rises.
- Backdoor port:
  - load_en writes mem[load_addr] on that edge.
  - If it hits the same byte as a simultaneous SPI write, the SPI write wins.
  - A backdoor write to the byte currently being read is visible only from the next byte fetch. Each byte is latched into a shift register when its bit 0 is driven.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package nanov_spi_pkg:
  - constants SPI_CMD_READ=8'h03, SPI_CMD_WRITE=8'h02
  - state enum (IDLE, CMD, ADDR, READ, WRITE, IGNORE)
- Same package is reused by the master-side flash model.
- One sub-module: nanov_spi_ram_mem, a single-port-plus-backdoor byte RAM (SPI write port has priority, combinational read on addr). The FSM stays in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, select high.
  - Required: spi_miso=0, busy=0, cmd_error=0.
- Sequential read:
  - Stimulus: preload via backdoor 0x010: 0x93, 0x011: 0x00. Send 0x03 then address 0x000010 with enable held high, then 16 bit cycles.
  - Required: miso bits = 1,1,0,0,1,0,0,1 then 8 zeros. The first bit appears on the cycle after the last address bit.
- Write then read back:
  - Stimulus: 0x02, address 0x000020, 16 data bits (LSB first) forming 0xA5, 0x3C. Deassert select, then read 0x000020.
  - Required: mem[0x20]=0xA5, mem[0x21]=0x3C; readback stream matches.
- Clock-enable gaps and wrap:
  - Stimulus: read at 0xFFF (MEM_BYTES=4096) with spi_clk_enable dropped for 3 cycles mid-byte.
  - Required: miso held during gaps; after byte 0xFFF, byte 0x000 streams out.
- Abort and bad command:
  - Stimulus: raise select after 5 write data bits, then read that byte. Separately send command 0x0B.
  - Required: the aborted byte is unchanged. 0x0B gives a one-cycle cmd_error pulse, miso stays 0 until select rises, busy=0 one cycle after the rise.
- High address bits:
  - Stimulus: read address 0x801004.
  - Required: the data returned is the byte at 0x004.
